// File: rtl/mode_counter.sv
// mode_counter: bounded up/down counter over 0..max-1 with wrap or saturate
// behaviour, an enable prescaler, synchronous clear/load and a registered
// terminal-count pulse.
module mode_counter #(
  parameter int DATA_SIZE = 4,
  parameter int PRESCALE  = 1,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 counting,
  input  logic                 up_dn,
  input  logic                 clear,
  input  logic                 load,
  input  logic [DATA_SIZE-1:0] load_val,
  input  logic [DATA_SIZE-1:0] max,
  output logic [DATA_SIZE-1:0] ctr_out,
  output logic                 tc,
  output logic                 at_bound
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0]     PRE_ONE  = PRE_W'(1);
  localparam logic [DATA_SIZE-1:0] ONE      = DATA_SIZE'(1);

  logic [PRE_W-1:0]     pre;
  logic                 max_zero;
  logic [DATA_SIZE-1:0] max_m1;
  logic [DATA_SIZE-1:0] load_clamp;
  logic                 step;
  logic [DATA_SIZE:0]   step_res;

  // Next {tc, count} for one step. max-1 is supplied pre-computed and is only
  // meaningful when max != 0; the max == 0 case forces the count to 0.
  function automatic logic [DATA_SIZE:0] step_next(
    input logic [DATA_SIZE-1:0] cur,
    input logic [DATA_SIZE-1:0] mx,
    input logic [DATA_SIZE-1:0] mx_m1,
    input logic                 mx_zero,
    input logic                 dir_up
  );
    logic [DATA_SIZE-1:0] nxt;
    logic                 pulse;
    nxt   = cur;
    pulse = 1'b0;
    if (mx_zero) begin
      nxt = '0;
    end else if (dir_up) begin
      if (cur < mx_m1) begin
        nxt   = cur + ONE;
        pulse = SATURATE && (nxt == mx_m1);
      end else if (SATURATE) begin
        // Already at (or beyond, after max was lowered) the upper bound.
        nxt   = mx_m1;
        pulse = (cur >= mx);
      end else begin
        nxt   = '0;
        pulse = 1'b1;
      end
    end else begin
      if (cur >= mx) begin
        // Out of range after max was lowered: snap to top without a pulse.
        nxt = mx_m1;
      end else if (cur == '0) begin
        if (!SATURATE) begin
          nxt   = mx_m1;
          pulse = 1'b1;
        end
      end else begin
        nxt   = cur - ONE;
        pulse = SATURATE && (cur == ONE);
      end
    end
    return {pulse, nxt};
  endfunction

  assign max_zero   = (max == '0);
  assign max_m1     = max_zero ? '0 : (max - ONE);
  assign load_clamp = max_zero ? '0 : ((load_val >= max) ? max_m1 : load_val);
  assign step       = counting && (pre == PRE_LAST);
  assign step_res   = step_next(ctr_out, max, max_m1, max_zero, up_dn);
  assign at_bound   = !max_zero && (up_dn ? (ctr_out == max_m1) : (ctr_out == '0));

  // Counter, prescaler and tc register: clear > load > step > hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_out <= '0;
      pre     <= '0;
      tc      <= 1'b0;
    end else if (clear) begin
      ctr_out <= '0;
      pre     <= '0;
      tc      <= 1'b0;
    end else if (load) begin
      ctr_out <= load_clamp;
      pre     <= '0;
      tc      <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (counting) begin
        pre <= (pre == PRE_LAST) ? '0 : (pre + PRE_ONE);
        if (step) begin
          {tc, ctr_out} <= step_res;
        end
      end
    end
  end

endmodule
